// File: rtl/mips_avalon_ram_slave.sv
// mips_avalon_ram_slave
//
// Word-organised RAM behind an Avalon-MM responder port, used by CPU testbenches to
// serve instruction fetches and load/store traffic with a programmable waitrequest
// stall so the master's stall handling is exercised.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high reset (memory contents are kept)
//   address      byte address from the master
//   write/read   request strobes; exactly one must be high for a transfer
//   waitrequest  stall, master holds its request while high
//   writedata    store data
//   byteenable   lane enables, bit n covers bits [8n+7:8n]
//   readdata     read data, non-zero only in the completing cycle of a read
//   bus_error    sticky protocol/address error flag, cleared only by reset
//
// Optional feature macro: RANDOM_WAIT_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) picks a
//   stall of 0..WAIT_CYCLES per accepted request. When undefined the stall is always
//   exactly WAIT_CYCLES and no LFSR exists.
//
// Simulation note: the memory array is zero-filled at time 0.

module mips_avalon_ram_slave #(
    parameter logic [31:0] MEM_BASE    = 32'hBFC00000,
    parameter int unsigned MEM_WORDS   = 4096,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        bus_error_q, bus_error_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        op_wr_q, op_wr_d;

    logic [31:0] mem [MEM_WORDS];

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i] = '0;
        end
    end

    // Address decode on the live bus; during WAIT/ACK the bus must equal the latched
    // request, so decoding the live value is equivalent.
    logic [29:0]     word_off;
    logic [IdxW-1:0] word_idx;
    logic            addr_ok;

    assign word_off = address[31:2] - MEM_BASE[31:2];
    assign word_idx = word_off[IdxW-1:0];
    // Addresses below MEM_BASE wrap to large offsets and fail the range test.
    assign addr_ok  = (address[1:0] == 2'b00) && ({2'b00, word_off} < 32'(MEM_WORDS));

    logic req_one;
    logic req_both;
    logic match;

    assign req_one  = read ^ write;
    assign req_both = read & write;
    assign match    = req_one && (write == op_wr_q) && (address == addr_q) &&
                      (byteenable == be_q) && (writedata == wdata_q);

    // Stall length for a request accepted in IDLE.
    logic [3:0] stall;
    logic       accept;

`ifdef RANDOM_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign stall  = 4'(32'(lfsr_q[3:0]) % (WAIT_CYCLES + 1));
    assign lfsr_d = accept ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                           : lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = 4'(WAIT_CYCLES);
`endif

    logic complete;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_error_d = bus_error_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        op_wr_d     = op_wr_q;
        waitrequest = 1'b0;
        complete    = 1'b0;
        accept      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_both) begin
                    bus_error_d = 1'b1;
                end else if (req_one) begin
                    accept = 1'b1;
                    if (stall == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        waitrequest = 1'b1;
                        addr_d      = address;
                        wdata_d     = writedata;
                        be_d        = byteenable;
                        op_wr_d     = write;
                        cnt_d       = stall - 4'd1;
                        state_d     = (stall == 4'd1) ? StAck : StWait;
                    end
                end
            end
            StWait: begin
                waitrequest = 1'b1;
                if (!match) begin
                    bus_error_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_d == 4'd0) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
                if (!match) begin
                    bus_error_d = 1'b1;
                end else begin
                    complete = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (complete && !addr_ok) begin
            bus_error_d = 1'b1;
        end
    end

    logic mem_we;

    // A reset in the completing cycle discards the write.
    assign mem_we    = complete && write && addr_ok && !reset;
    assign readdata  = (complete && read && addr_ok) ? mem[word_idx] : 32'h0;
    assign bus_error = bus_error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            bus_error_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            op_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            op_wr_q     <= op_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem[word_idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

endmodule
